// File: rtl/usf_modulo_fold_multi.sv
// Multi-channel modulo folder: captures a frame of signed samples and folds each
// lane into [-LAMBDA, LAMBDA-1] with a shared, fixed-length restoring reduction.
module usf_modulo_fold_multi #(
   parameter int CHANNELS = 13,
   parameter int IN_W     = 16,
   parameter int OUT_W    = 12,
   parameter int LAMBDA   = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic signed [IN_W-1:0]  in  [CHANNELS],
   output logic signed [OUT_W-1:0] out [CHANNELS],
   output logic                    busy,
   output logic                    valid
);

   localparam int W    = IN_W + OUT_W + 2;
   localparam int MOD  = 2 * LAMBDA;
   localparam int BIAS = MOD * ((2 ** (IN_W - 1) + MOD - 1) / MOD);
   localparam int KW   = $clog2(IN_W + 1);

   localparam logic [W-1:0]  MOD_W    = W'(MOD);
   localparam logic [W-1:0]  BIAS_W   = W'(BIAS);
   localparam logic [W-1:0]  LAMBDA_W = W'(LAMBDA);
   localparam logic [KW-1:0] K_START  = KW'(IN_W);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REDUCE = 2'd1;
   localparam logic [1:0] STORE  = 2'd2;

   logic [1:0]    state;
   logic [KW-1:0] k;
   logic [W-1:0]  r [CHANNELS];
   logic [W-1:0]  mod_k;

   // Subtrahend for the current step, shared by every lane.
   assign mod_k = MOD_W << k;
   assign busy  = (state != IDLE);

   // NOTE: every register here, including the residue array, is cleared on
   // reset so an aborted frame leaves nothing behind; all state updates use <=.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         k     <= '0;
         valid <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            r[c]   <= '0;
            out[c] <= '0;
         end
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  // Bias makes the residue non-negative for any signed input.
                  for (int c = 0; c < CHANNELS; c++)
                     r[c] <= {{(W-IN_W){in[c][IN_W-1]}}, in[c]} + LAMBDA_W + BIAS_W;
                  k     <= K_START;
                  state <= REDUCE;
               end
            end
            REDUCE: begin
               for (int c = 0; c < CHANNELS; c++)
                  if (r[c] >= mod_k) r[c] <= r[c] - mod_k;
               if (k == '0) state <= STORE;
               else         k     <= k - 1'b1;
            end
            STORE: begin
               // Residue is now in [0, MOD-1], so the shifted value fits OUT_W.
               for (int c = 0; c < CHANNELS; c++)
                  out[c] <= OUT_W'(r[c] - LAMBDA_W);
               valid <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
